// File: rtl/sw_input_port_pkg.sv
// Shared CPU constants: I/O port map plus the button debouncer state encoding
// and default stability window.
package sw_input_port_pkg;

    localparam logic [7:0] IO_PORT_SW   = 8'h00;
    localparam logic [7:0] IO_PORT_LED  = 8'h01;

    localparam int DEB_CYCLES_DEFAULT = 20;

    typedef enum logic [1:0] {
        DEB_LO     = 2'd0,
        DEB_CHK_HI = 2'd1,
        DEB_HI     = 2'd2,
        DEB_CHK_LO = 2'd3
    } deb_state_e;

    function automatic int deb_cnt_width(input int cycles);
        return ($clog2(cycles) < 1) ? 1 : $clog2(cycles);
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// Button synchronizer and debounce FSM; commit is a one-cycle pulse on the
// cycle the FSM accepts a low-to-high level change.
module btn_debounce
    import sw_input_port_pkg::*;
#(
    parameter int DEB_CYCLES = DEB_CYCLES_DEFAULT
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn,
    output logic btn_s,
    output logic commit
);

    localparam int CW = deb_cnt_width(DEB_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEB_CYCLES - 1);

    logic [1:0]    sync_q;
    deb_state_e    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;

    assign btn_s = sync_q[1];

    // Commit fires combinationally from registered state so Valid can be
    // registered on the very edge that enters HI.
    assign commit = (state_q == DEB_CHK_HI) && btn_s && (cnt_q == CNT_LAST);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            DEB_LO: begin
                if (btn_s) begin
                    state_d = DEB_CHK_HI;
                    cnt_d   = '0;
                end
            end
            DEB_CHK_HI: begin
                if (!btn_s) begin
                    state_d = DEB_LO;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = DEB_HI;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DEB_HI: begin
                if (!btn_s) begin
                    state_d = DEB_CHK_LO;
                    cnt_d   = '0;
                end
            end
            DEB_CHK_LO: begin
                if (btn_s) begin
                    state_d = DEB_HI;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = DEB_LO;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = DEB_LO;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q  <= 2'b00;
            state_q <= DEB_LO;
            cnt_q   <= '0;
        end else begin
            sync_q  <= {sync_q[0], btn};
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: rtl/sw_input_port.sv
// Switch input port: a debounced button press captures the switches into a
// one-deep holding register read by the CPU; dropped presses set sticky Ovf.
module sw_input_port
    import sw_input_port_pkg::*;
#(
    parameter int DEB_CYCLES = DEB_CYCLES_DEFAULT
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic [7:0] Sw,
    input  logic       Btn,
    input  logic       Rd,
    output logic [7:0] Data_out,
    output logic       Valid,
    output logic       Ovf
);

    logic [7:0] sw_meta_q, sw_s_q;
    logic [7:0] data_q, data_d;
    logic       valid_q, valid_d;
    logic       ovf_q, ovf_d;
    logic       btn_s;
    logic       commit;

    btn_debounce #(
        .DEB_CYCLES (DEB_CYCLES)
    ) u_debounce (
        .clk    (CLK),
        .rst_n  (RST),
        .btn    (Btn),
        .btn_s  (btn_s),
        .commit (commit)
    );

    // A read coinciding with a commit hands the CPU the fresh value instead
    // of counting the press as dropped.
    always_comb begin
        data_d  = data_q;
        valid_d = valid_q;
        ovf_d   = ovf_q;
        if (commit) begin
            if (!valid_q || Rd) begin
                data_d  = sw_s_q;
                valid_d = 1'b1;
            end else begin
                ovf_d = 1'b1;
            end
        end else if (Rd && valid_q) begin
            valid_d = 1'b0;
            ovf_d   = 1'b0;
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            sw_meta_q <= 8'h00;
            sw_s_q    <= 8'h00;
            data_q    <= 8'h00;
            valid_q   <= 1'b0;
            ovf_q     <= 1'b0;
        end else begin
            sw_meta_q <= Sw;
            sw_s_q    <= sw_meta_q;
            data_q    <= data_d;
            valid_q   <= valid_d;
            ovf_q     <= ovf_d;
        end
    end

    assign Data_out = data_q;
    assign Valid    = valid_q;
    assign Ovf      = ovf_q;

    logic unused_btn_s;
    assign unused_btn_s = btn_s;

endmodule

// File: tb/tb_sw_input_port.sv
// Randomized and directed bench for sw_input_port with a run-length reference
// model feeding a per-cycle scoreboard.
module tb_sw_input_port;

    localparam int DEB = 4;

    logic       CLK = 1'b0;
    logic       RST = 1'b0;
    logic [7:0] Sw  = 8'h00;
    logic       Btn = 1'b0;
    logic       Rd  = 1'b0;
    logic [7:0] Data_out;
    logic       Valid;
    logic       Ovf;

    sw_input_port #(.DEB_CYCLES(DEB)) dut (
        .CLK      (CLK),
        .RST      (RST),
        .Sw       (Sw),
        .Btn      (Btn),
        .Rd       (Rd),
        .Data_out (Data_out),
        .Valid    (Valid),
        .Ovf      (Ovf)
    );

    always #5 CLK = ~CLK;

    typedef struct packed {
        logic       valid;
        logic [7:0] data;
        logic       ovf;
    } exp_t;

    exp_t sbq[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // Reference model: a level change is accepted once the synchronized button
    // has disagreed with the accepted level for DEB+1 consecutive samples.
    logic       m_b1, m_b2, m_lvl;
    logic [7:0] m_s1, m_s2;
    int         m_run;
    exp_t       m_out;

    always @(posedge CLK or negedge RST) begin : model
        exp_t nxt;
        int   run_n;
        logic lvl_n;
        logic cmt;
        if (!RST) begin
            m_b1  <= 1'b0;
            m_b2  <= 1'b0;
            m_lvl <= 1'b0;
            m_s1  <= 8'h00;
            m_s2  <= 8'h00;
            m_run <= 0;
            m_out <= '0;
            sbq.delete();
            sbq.push_back('0);
        end else begin
            run_n = m_run;
            lvl_n = m_lvl;
            cmt   = 1'b0;
            if (m_b2 != m_lvl) begin
                run_n = m_run + 1;
                if (run_n == DEB + 1) begin
                    lvl_n = m_b2;
                    run_n = 0;
                    cmt   = m_b2;
                end
            end else begin
                run_n = 0;
            end
            nxt = m_out;
            if (cmt) begin
                if (!m_out.valid || Rd) begin
                    nxt.valid = 1'b1;
                    nxt.data  = m_s2;
                end else begin
                    nxt.ovf = 1'b1;
                end
            end else if (Rd && m_out.valid) begin
                nxt.valid = 1'b0;
                nxt.ovf   = 1'b0;
            end
            m_run <= run_n;
            m_lvl <= lvl_n;
            m_out <= nxt;
            m_b2  <= m_b1;
            m_b1  <= Btn;
            m_s2  <= m_s1;
            m_s1  <= Sw;
            sbq.push_back(nxt);
        end
    end

    always @(negedge CLK) begin : monitor
        exp_t e;
        if (sbq.size() == 0) begin
            n_checks++;
            $display("FAIL sb_underflow: scoreboard empty at %0t", $time);
        end else begin
            e = sbq.pop_front();
            check("sb_valid", 32'(Valid),    32'(e.valid));
            check("sb_data",  32'(Data_out), 32'(e.data));
            check("sb_ovf",   32'(Ovf),      32'(e.ovf));
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge CLK);
    endtask

    task automatic rd_pulse();
        Rd = 1'b1;
        @(negedge CLK);
        Rd = 1'b0;
    endtask

    // Counts edges from the current negedge until Valid is seen high.
    task automatic wait_valid(input string name, input int exp_edges);
        int edges;
        edges = 0;
        while (Valid !== 1'b1 && edges < 40) begin
            @(negedge CLK);
            edges++;
        end
        check(name, 32'(edges), 32'(exp_edges));
    endtask

    task automatic press(input logic [7:0] sw_val, input string name);
        Sw  = sw_val;
        Btn = 1'b1;
        wait_valid(name, DEB + 3);
    endtask

    task automatic release_btn();
        Btn = 1'b0;
        tick(DEB + 6);
    endtask

    initial begin
        tick(3);
        check("rst_valid", 32'(Valid),    32'd0);
        check("rst_data",  32'(Data_out), 32'h00);
        check("rst_ovf",   32'(Ovf),      32'd0);
        RST = 1'b1;
        tick(3);

        // Clean press latency and capture
        press(8'h0A, "lat_press");
        check("press_data", 32'(Data_out), 32'h0A);
        check("press_ovf",  32'(Ovf),      32'd0);
        tick(3);
        rd_pulse();
        check("read_clr_valid", 32'(Valid),    32'd0);
        check("read_keep_data", 32'(Data_out), 32'h0A);
        release_btn();

        // Bounce 1,0,1,0 then hold
        Sw = 8'h21;
        Btn = 1'b1; tick(1);
        Btn = 1'b0; tick(1);
        Btn = 1'b1; tick(1);
        Btn = 1'b0; tick(1);
        Btn = 1'b1;
        wait_valid("lat_bounce", DEB + 3);
        check("bounce_data", 32'(Data_out), 32'h21);
        rd_pulse();
        tick(20);
        check("bounce_single", 32'(Valid), 32'd0);
        release_btn();

        // Dropped press sets Ovf, read clears both
        press(8'h0A, "lat_first");
        release_btn();
        Sw  = 8'h55;
        Btn = 1'b1;
        tick(DEB + 8);
        check("ovf_valid", 32'(Valid),    32'd1);
        check("ovf_data",  32'(Data_out), 32'h0A);
        check("ovf_set",   32'(Ovf),      32'd1);
        rd_pulse();
        check("ovf_rd_valid", 32'(Valid), 32'd0);
        check("ovf_rd_ovf",   32'(Ovf),   32'd0);
        release_btn();

        // Read on the same edge as a commit
        press(8'h11, "lat_pre");
        release_btn();
        Sw  = 8'h3C;
        Btn = 1'b1;
        tick(DEB + 2);
        rd_pulse();
        check("coin_valid", 32'(Valid),    32'd1);
        check("coin_data",  32'(Data_out), 32'h3C);
        check("coin_ovf",   32'(Ovf),      32'd0);
        rd_pulse();
        release_btn();

        // Asynchronous reset mid-debounce, then full debounce again
        press(8'h77, "lat_pre_rst");
        release_btn();
        Btn = 1'b1;
        tick(5);
        #2 RST = 1'b0;
        #1;
        check("arst_valid", 32'(Valid),    32'd0);
        check("arst_data",  32'(Data_out), 32'h00);
        check("arst_ovf",   32'(Ovf),      32'd0);
        tick(2);
        RST = 1'b1;
        wait_valid("lat_after_rst", DEB + 3);
        check("after_rst_data", 32'(Data_out), 32'h77);

        // Long hold gives one commit only
        tick(100);
        check("hold_valid", 32'(Valid), 32'd1);
        rd_pulse();
        check("hold_rd", 32'(Valid), 32'd0);
        tick(30);
        check("hold_no_recommit", 32'(Valid), 32'd0);
        release_btn();
        press(8'hC3, "lat_repress");
        check("repress_data", 32'(Data_out), 32'hC3);
        rd_pulse();
        release_btn();

        // Random traffic
        for (int i = 0; i < 500; i++) begin
            Sw = 8'($urandom);
            if ($urandom_range(0, 5) == 0) Btn = ~Btn;
            Rd = ($urandom_range(0, 7) == 0);
            @(negedge CLK);
        end
        Rd  = 1'b0;
        Btn = 1'b0;
        tick(4);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/sw_input_port.md
SW_INPUT_PORT -- requirements
Module: sw_input_port

Interface
REQ-001 Parameter DEB_CYCLES, default 20, means consecutive stable synchronized cycles required to accept a button level change; legal range 2..65535.
REQ-002 CLK  input  1  means the single system clock; all state updates on the rising edge.
REQ-003 RST  input  1  means asynchronous, active-low reset.
REQ-004 Sw  input  8  means raw board switches, the data value to be delivered to the CPU.
REQ-005 Btn  input  1  means raw push button (bouncy); a debounced press commits Sw.
REQ-006 Rd  input  1  means single-cycle CPU read strobe (IN instruction) consuming the held value.
REQ-007 Data_out  output  8  means the committed switch value, stable while Valid=1.
REQ-008 Valid  output  1  means a committed value is waiting for the CPU.
REQ-009 Ovf  output  1  means sticky flag: a press was dropped because Valid was already 1.

Function
REQ-010 Sw and Btn shall each pass through a 2-flop synchronizer (sw_s, btn_s) before any other use.
REQ-011 The debounce FSM shall have states LO, CHK_HI, HI, CHK_LO; reset state is LO.
REQ-012 LO -> CHK_HI when btn_s=1, counter cleared to 0; LO otherwise holds.
REQ-013 In CHK_HI: btn_s=0 -> LO (no commit); btn_s=1 and cnt<DEB_CYCLES-1 -> cnt+1; btn_s=1 and cnt=DEB_CYCLES-1 -> HI with a commit event.
REQ-014 HI -> CHK_LO on btn_s=0 with cnt cleared; CHK_LO mirrors CHK_HI with opposite polarity, returning to HI on a glitch and to LO without any event.
REQ-015 Latency: with Btn held high, Valid shall rise on exactly clock edge DEB_CYCLES+3 counted from the first edge that samples Btn=1.
REQ-016 A commit event with Valid=0 shall load Data_out with sw_s of that cycle and set Valid.
REQ-017 A commit event with Valid=1 and Rd=0 shall leave Data_out unchanged and set Ovf.
REQ-018 A commit event coinciding with Rd=1 shall load the new sw_s, keep Valid=1, and leave Ovf unchanged.
REQ-019 Rd=1 with Valid=1 and no commit shall clear Valid and Ovf on the next edge; Data_out retains its last value.
REQ-020 Rd=1 with Valid=0 shall have no effect.
REQ-021 Holding Btn indefinitely shall produce exactly one commit; another requires passing through LO.
REQ-022 The counter width shall be $clog2(DEB_CYCLES) bits, minimum 1, with no wrap inside CHK states.

Reset
REQ-023 RST=0 shall immediately force FSM=LO, cnt=0, synchronizer flops=0, Data_out=8'h00, Valid=0, Ovf=0, regardless of any operation in progress.
REQ-024 After RST deasserts with Btn already high, a full debounce (REQ-015) shall occur before any commit.

Structure
REQ-025 FSM state encodings and the DEB_CYCLES default shall reside in the shared CPU constants package alongside existing I/O port definitions.
REQ-026 The debouncer (synchronizer, counter, FSM, single-cycle commit pulse) shall be a sub-module named btn_debounce; the commit/Valid/Ovf register logic stays in sw_input_port.

Verification (DEB_CYCLES=4, 10 ns clock)
REQ-027 Sw=8'h0A, Btn 0->1 held -> Valid=1 on edge 7, Data_out=8'h0A, Ovf=0.
REQ-028 Btn bounces 1,0,1,0 on successive cycles then held 1 -> exactly one commit, Valid rises 7 edges after the final 0->1.
REQ-029 Valid=1 with Data_out=8'h0A, Sw=8'h55, second full press, no Rd -> Data_out stays 8'h0A, Ovf=1; then Rd pulse -> Valid=0, Ovf=0 next edge.
REQ-030 Rd pulsed on the same edge as a commit with Sw=8'h3C -> Valid stays 1, Data_out=8'h3C, Ovf=0.
REQ-031 RST=0 asserted during CHK_HI with cnt=2 -> all outputs 0 asynchronously; after release with Btn still high, Valid=1 only after 7 further edges.
REQ-032 Btn held high for 100 cycles after commit, Rd pulsed -> Valid=0 and no further commit until Btn released and pressed again.
